// File: rtl/adc_frame_ctrl_if.sv
// AXI-Stream style frame output bus between the ADC frame controller and
// the downstream wavelet engine.
interface adc_frame_ctrl_if #(
    parameter int ADC_WIDTH = 14
);
    logic [ADC_WIDTH-1:0] m_tdata;
    logic                 m_tvalid;
    logic                 m_tlast;
    logic                 m_tready;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/adc_frame_ctrl.sv
// ADC frame capture controller: captures FRAME_LEN decimated samples per
// start request and streams them out through a one-entry AXI-Stream
// output register.
// Optional feature macro ADC_TRIG_EN: adds the ARMED state, the
// trig_level_i port and a rising-edge signed threshold trigger.
module adc_frame_ctrl #(
    parameter int ADC_WIDTH   = 14,
    parameter int FRAME_LEN   = 1024,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [DECIM_WIDTH-1:0] decim_i,
`ifdef ADC_TRIG_EN
    input  logic [ADC_WIDTH-1:0]   trig_level_i,
`endif
    input  logic [ADC_WIDTH-1:0]   adc_data_i,
    input  logic                   adc_data_valid_i,
    adc_frame_ctrl_if.master       m_axis,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   overflow_o
);

    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
`ifdef ADC_TRIG_EN
        S_ARMED   = 2'd1,
`endif
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [DECIM_WIDTH-1:0] decim_q, decim_d;
    logic [DECIM_WIDTH-1:0] phase_q, phase_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADC_WIDTH-1:0]   tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic                   done_q, done_d;
    logic                   ovf_q, ovf_d;
`ifdef ADC_TRIG_EN
    logic [ADC_WIDTH-1:0]   prev_q, prev_d;
    logic                   prev_ok_q, prev_ok_d;
`endif

    logic                   accept;
    logic                   is_last;
    logic                   out_free;
    logic                   ratio_one;
    logic [DECIM_WIDTH-1:0] phase_step;

    // Decimation phase arithmetic: ratios 0 and 1 keep the phase at zero.
    always_comb begin
        ratio_one  = (decim_q <= DECIM_WIDTH'(1));
        phase_step = phase_q + DECIM_WIDTH'(1);
        if (ratio_one || (phase_q >= decim_q - DECIM_WIDTH'(1))) begin
            phase_step = '0;
        end
    end

    // Next-state logic for the FSM, counters and the output register.
    always_comb begin
        state_d   = state_q;
        decim_d   = decim_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        tdata_d   = tdata_q;
        tvalid_d  = tvalid_q;
        tlast_d   = tlast_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
`ifdef ADC_TRIG_EN
        prev_d    = prev_q;
        prev_ok_d = prev_ok_q;
`endif
        accept    = 1'b0;
        is_last   = (cnt_q == LAST_IDX);
        out_free  = !tvalid_q || m_axis.m_tready;

        if (abort_i) begin
            // Abort beats everything, including a simultaneous start.
            state_d  = S_IDLE;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else begin
            // A completed handshake empties the register unless reloaded below.
            if (tvalid_q && m_axis.m_tready) begin
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        decim_d = decim_i;
                        phase_d = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
`ifdef ADC_TRIG_EN
                        prev_ok_d = 1'b0;
                        state_d   = S_ARMED;
`else
                        state_d   = S_CAPTURE;
`endif
                    end
                end
`ifdef ADC_TRIG_EN
                S_ARMED: begin
                    if (adc_data_valid_i) begin
                        prev_d    = adc_data_i;
                        prev_ok_d = 1'b1;
                        // Rising crossing of the threshold; needs a previous sample.
                        if (prev_ok_q &&
                            ($signed(prev_q) < $signed(trig_level_i)) &&
                            ($signed(adc_data_i) >= $signed(trig_level_i))) begin
                            accept  = 1'b1;
                            state_d = S_CAPTURE;
                            phase_d = ratio_one ? '0 : DECIM_WIDTH'(1);
                        end
                    end
                end
`endif
                S_CAPTURE: begin
                    if (adc_data_valid_i) begin
                        phase_d = phase_step;
                        accept  = (phase_q == '0);
                    end
                end
                S_DRAIN: begin
                    if (tvalid_q && m_axis.m_tready && tlast_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (accept) begin
                cnt_d = is_last ? '0 : cnt_q + CNT_W'(1);
                if (is_last) begin
                    state_d = S_DRAIN;
                end
                if (out_free) begin
                    tdata_d  = adc_data_i;
                    tvalid_d = 1'b1;
                    tlast_d  = is_last;
                end else begin
                    // Dropped sample still counts; a dropped last sample
                    // marks the held beat as end of frame instead.
                    ovf_d = 1'b1;
                    if (is_last) begin
                        tlast_d = 1'b1;
                    end
                end
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            decim_q   <= '0;
            phase_q   <= '0;
            cnt_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef ADC_TRIG_EN
            prev_q    <= '0;
            prev_ok_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            decim_q   <= decim_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
            tlast_q   <= tlast_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
`ifdef ADC_TRIG_EN
            prev_q    <= prev_d;
            prev_ok_q <= prev_ok_d;
`endif
        end
    end

    assign m_axis.m_tdata  = tdata_q;
    assign m_axis.m_tvalid = tvalid_q;
    assign m_axis.m_tlast  = tlast_q;
    assign busy_o          = (state_q != S_IDLE);
    assign frame_done_o    = done_q;
    assign overflow_o      = ovf_q;

endmodule

// File: doc/adc_frame_ctrl.md
ADC_FRAME_CTRL -- requirements
Module: adc_frame_ctrl

Interface
REQ-001 Parameter ADC_WIDTH, default 14: sample width in bits, two's complement.
REQ-002 Parameter FRAME_LEN, default 1024: number of samples per captured frame, range 2..65535.
REQ-003 Parameter DECIM_WIDTH, default 8: width of the decimation ratio input.
REQ-004 Port clk, input, 1: single clock for all logic.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port start, input, 1: single-cycle request to capture one frame.
REQ-007 Port abort, input, 1: cancel the capture in progress.
REQ-008 Port decim, input, DECIM_WIDTH: decimation ratio; 0 and 1 both mean every sample.
REQ-009 Port trig_level, input, ADC_WIDTH: signed trigger threshold (present only with ADC_TRIG_EN).
REQ-010 Port adc_data_in, input, ADC_WIDTH: sample from the ADC sampling stage.
REQ-011 Port adc_data_valid, input, 1: adc_data_in is a new sample this cycle.
REQ-012 Port m_tdata, output, ADC_WIDTH: frame sample to the wavelet engine.
REQ-013 Port m_tvalid / m_tlast, output, 1 each: AXI-Stream valid and last-of-frame.
REQ-014 Port m_tready, input, 1: downstream accept.
REQ-015 Port busy, frame_done, overflow, output, 1 each: status signals.

Function
REQ-016 States: IDLE, ARMED, CAPTURE, DRAIN.
REQ-017 IDLE: start moves to ARMED with ADC_TRIG_EN, otherwise to CAPTURE; decim is latched on that cycle; overflow is cleared.
REQ-018 start is ignored outside IDLE; decim changes after the latch cycle have no effect.
REQ-019 ARMED: trigger = valid sample with prev < trig_level AND cur >= trig_level, signed compare; prev is the last valid sample seen in ARMED; the first valid sample in ARMED never triggers.
REQ-020 The triggering sample is accepted as frame sample 0; the decimation counter restarts at that sample.
REQ-021 CAPTURE: accept valid samples whose decimation phase is 0; the phase counter increments only on adc_data_valid and wraps at latched decim-1.
REQ-022 Accepted sample at cycle N appears on m_tdata with m_tvalid=1 at cycle N+1 (1-entry output register).
REQ-023 AXIS rules: m_tdata and m_tlast hold stable while m_tvalid=1 and m_tready=0; the register loads when empty or emptied in the same cycle (m_tvalid and m_tready both high).
REQ-024 On an accepted sample with the register full and m_tready=0, the sample is dropped, overflow is set (sticky until the next start), and the sample still counts toward FRAME_LEN.
REQ-025 The sample counter counts accepted samples 0..FRAME_LEN-1; m_tlast=1 on sample FRAME_LEN-1 (if that sample is dropped, the currently held sample gets m_tlast forced high).
REQ-026 After the last sample is accepted -> DRAIN; DRAIN waits for the m_tlast handshake, then returns to IDLE.
REQ-027 frame_done: one-cycle pulse on the cycle after the m_tlast handshake.
REQ-028 busy=1 in every state except IDLE.
REQ-029 abort in any state: IDLE on the next edge; m_tvalid and m_tlast cleared; frame_done not pulsed; overflow held.
REQ-030 If abort and start are both high in IDLE, abort wins and the block stays in IDLE.

Reset
REQ-031 On rst: state IDLE; m_tvalid, m_tlast, busy, frame_done, overflow=0; m_tdata, counters, prev and latched decim=0.
REQ-032 Reset mid-frame discards the frame with no frame_done pulse; the first start after deassertion behaves normally.

Configuration
REQ-033 Macro ADC_TRIG_EN defined: ARMED state, trig_level port and threshold trigger are compiled in.
REQ-034 Macro ADC_TRIG_EN undefined: no trig_level port and no ARMED state; start goes straight to CAPTURE and the first valid sample after start is sample 0.

Verification
REQ-035 FRAME_LEN=8, decim=1, m_tready=1, ramp 0..: start -> 8 beats 0..7, m_tlast on 7, frame_done one cycle after, busy low.
REQ-036 decim=3, ramp input: m_tdata = 0,3,6,... (with trigger: trigger sample, +3, +6).
REQ-037 ADC_TRIG_EN, trig_level=100, samples 90,99,100,101: trigger on 100; frame starts 100,101; repeat with 100,100 sequence -> no trigger on second sample.
REQ-038 m_tready=0 for 3 accepted samples: first held stable, next two dropped, overflow=1 until the next start, frame still ends after 8 accepted samples.
REQ-039 abort mid-CAPTURE -> IDLE next cycle, m_tvalid=0, no frame_done; abort+start same cycle in IDLE -> stays IDLE.
REQ-040 rst asserted asynchronously mid-frame -> all outputs 0 immediately; next start captures a full frame.
